fastfir_taploader: RTL and testbench

- Write-side companion to the fast FIR tap-load interface.
- On command, it reads NTAPS coefficients from an external coefficient memory and streams them into the filter's tap_wr/tap port, one tap per clock.
- While a load is in progress it gates the filter's sample clock-enable, so no sample is filtered against a partial tap set.
- Sits between the host/coefficient RAM and a reloadable (non-FIXED_TAPS) fastfir instance.

---
 rtl/fastfir_taploader_pkg.sv | 26 ++
 rtl/fastfir_taploader.sv | 122 ++++++++++++
 tb/tb_fastfir_taploader.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fastfir_taploader_pkg.sv
// Shared definitions for the fast FIR tap loader: FSM encoding, address-width
// helper and the coefficient load order shared with FIR reference models.
package fastfir_taploader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } tl_state_e;

    // Coefficients are streamed from the highest address down, so coefficient 0
    // is the last one written and ends at the head of the FIR tap line.
    localparam bit TAP_LOAD_HIGH_TO_LOW = 1'b1;

    function automatic int lg_ntaps(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fastfir_taploader.sv
// Streams NTAPS coefficients from coefficient memory into a reloadable fast FIR,
// gating the filter's sample clock-enable until the complete tap set has landed.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no load in progress; samples pass through to the FIR
// ST_LOAD  | one coefficient read per cycle, address walking the tap set
// ST_DRAIN | final tap write in flight; done/loaded asserted on exit
module fastfir_taploader
    import fastfir_taploader_pkg::*;
#(
    parameter  int NTAPS   = 128,
    parameter  int TW      = 12,
    localparam int LGNTAPS = lg_ntaps(NTAPS)
) (
    input  logic               i_clk,
    input  logic               i_areset_n,
    input  logic               i_start,
    input  logic               i_abort,
    output logic               o_mem_rd,
    output logic [LGNTAPS-1:0] o_mem_addr,
    input  logic [TW-1:0]      i_mem_data,
    output logic               o_tap_wr,
    output logic [TW-1:0]      o_tap,
    input  logic               i_ce,
    output logic               o_ce,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_loaded,
    output logic               o_dropped
);

    localparam logic [LGNTAPS-1:0] FIRST_ADDR =
        TAP_LOAD_HIGH_TO_LOW ? LGNTAPS'(NTAPS - 1) : '0;
    localparam logic [LGNTAPS-1:0] FINAL_ADDR =
        TAP_LOAD_HIGH_TO_LOW ? '0 : LGNTAPS'(NTAPS - 1);

    tl_state_e          state_q, state_d;
    logic [LGNTAPS-1:0] addr_q, addr_d;
    logic               tap_wr_q, tap_wr_d;
    logic [TW-1:0]      tap_q, tap_d;
    logic               done_q, done_d;
    logic               loaded_q, loaded_d;
    logic               mem_rd;
    logic               busy;

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            tap_wr_q <= 1'b0;
            tap_q    <= '0;
            done_q   <= 1'b0;
            loaded_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            tap_wr_q <= tap_wr_d;
            tap_q    <= tap_d;
            done_q   <= done_d;
            loaded_q <= loaded_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        done_d   = 1'b0;
        loaded_d = loaded_q;
        mem_rd   = (state_q == ST_LOAD);

        if (i_abort) begin
            state_d  = ST_IDLE;
            loaded_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        state_d  = ST_LOAD;
                        addr_d   = FIRST_ADDR;
                        loaded_d = 1'b0;
                    end
                end
                ST_LOAD: begin
                    // Counter parks on the final address; it only reloads on start.
                    if (addr_q == FINAL_ADDR) begin
                        state_d = ST_DRAIN;
                    end else if (TAP_LOAD_HIGH_TO_LOW) begin
                        addr_d = addr_q - LGNTAPS'(1);
                    end else begin
                        addr_d = addr_q + LGNTAPS'(1);
                    end
                end
                ST_DRAIN: begin
                    state_d  = ST_IDLE;
                    done_d   = 1'b1;
                    loaded_d = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        tap_wr_d = mem_rd && !i_abort;
        // Read data arrives alongside the write strobe; hold it for the idle cycles.
        tap_d    = tap_wr_q ? i_mem_data : tap_q;
    end

    assign busy       = (state_q != ST_IDLE);
    assign o_mem_rd   = mem_rd;
    assign o_mem_addr = addr_q;
    assign o_tap_wr   = tap_wr_q;
    assign o_tap      = tap_wr_q ? i_mem_data : tap_q;
    assign o_busy     = busy;
    assign o_done     = done_q;
    assign o_loaded   = loaded_q;
    // No sample reaches the FIR while reset is asserted or a tap set is partial.
    assign o_ce       = i_areset_n && i_ce && !busy;
    assign o_dropped  = i_ce && busy;

endmodule

// File: tb/tb_fastfir_taploader.sv
// Randomised self-checking bench for fastfir_taploader against a schedule model
// of the load timing and a shifting FIR tap-line model.
module tb_fastfir_taploader;
    import fastfir_taploader_pkg::*;

    localparam int N  = 16;
    localparam int TW = 9;
    localparam int LG = 4;

    logic          i_clk = 1'b0;
    logic          i_areset_n = 1'b0;
    logic          i_start = 1'b0;
    logic          i_abort = 1'b0;
    logic          o_mem_rd;
    logic [LG-1:0] o_mem_addr;
    logic [TW-1:0] i_mem_data;
    logic          o_tap_wr;
    logic [TW-1:0] o_tap;
    logic          i_ce = 1'b0;
    logic          o_ce;
    logic          o_busy;
    logic          o_done;
    logic          o_loaded;
    logic          o_dropped;

    fastfir_taploader #(.NTAPS(N), .TW(TW)) dut (
        .i_clk      (i_clk),
        .i_areset_n (i_areset_n),
        .i_start    (i_start),
        .i_abort    (i_abort),
        .o_mem_rd   (o_mem_rd),
        .o_mem_addr (o_mem_addr),
        .i_mem_data (i_mem_data),
        .o_tap_wr   (o_tap_wr),
        .o_tap      (o_tap),
        .i_ce       (i_ce),
        .o_ce       (o_ce),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_loaded   (o_loaded),
        .o_dropped  (o_dropped)
    );

    always #5 i_clk = ~i_clk;

    logic [TW-1:0] mem [N];
    logic [TW-1:0] mem_q = '0;
    logic [TW-1:0] fir [N];

    always @(posedge i_clk) begin
        if (o_mem_rd) mem_q <= mem[o_mem_addr];
    end
    assign i_mem_data = mem_q;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int wr_count = 0;
    int done_count = 0;

    // Load schedule model: a load accepted at edge m_t reads in cycles
    // m_t..m_t+N-1, writes in m_t+1..m_t+N, is busy m_t..m_t+N, done at m_t+N+1.
    bit m_active = 1'b0;
    int m_t = 0;
    bit m_loaded = 1'b0;
    int m_done_edge = -1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp_v, cyc);
        end
    endtask

    function automatic int tap_addr(input int k);
        return TAP_LOAD_HIGH_TO_LOW ? (N - 1 - k) : k;
    endfunction

    function automatic bit m_busy(input int p);
        return m_active && (p >= m_t) && (p <= m_t + N);
    endfunction

    task automatic model_edge(input logic s, input logic a);
        int  e;
        bit  prev_busy;
        e = cyc;
        prev_busy = m_busy(e - 1);
        if (a) begin
            if (prev_busy) m_active = 1'b0;
            m_loaded = 1'b0;
        end else begin
            if (m_active && e == m_t + N + 1) begin
                m_loaded = 1'b1;
                m_done_edge = e;
            end
            if (s && !prev_busy) begin
                m_active = 1'b1;
                m_t = e;
                m_loaded = 1'b0;
            end
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_loaded = 1'b0;
        m_done_edge = -1;
    endtask

    task automatic check_outputs();
        int p;
        bit e_busy, e_rd, e_wr;
        p = cyc;
        e_busy = m_busy(p);
        e_rd = m_active && (p >= m_t) && (p <= m_t + N - 1);
        e_wr = m_active && (p >= m_t + 1) && (p <= m_t + N);
        check_eq("busy", o_busy, e_busy);
        check_eq("mem_rd", o_mem_rd, e_rd);
        check_eq("tap_wr", o_tap_wr, e_wr);
        check_eq("done", o_done, (p == m_done_edge));
        check_eq("loaded", o_loaded, m_loaded);
        check_eq("ce", o_ce, i_ce && !e_busy);
        check_eq("dropped", o_dropped, i_ce && e_busy);
        if (e_rd) check_eq("mem_addr", o_mem_addr, tap_addr(p - m_t));
        if (e_wr) check_eq("tap", o_tap, mem[tap_addr(p - m_t - 1)]);
        if (o_tap_wr) begin
            wr_count++;
            for (int i = N - 1; i > 0; i--) fir[i] = fir[i - 1];
            fir[0] = o_tap;
        end
        if (o_done) begin
            done_count++;
            for (int i = 0; i < N; i++) check_eq("fir_tap", fir[i], mem[i]);
        end
    endtask

    task automatic step(input logic s, input logic a, input logic c);
        i_start = s;
        i_abort = a;
        i_ce = c;
        @(posedge i_clk);
        cyc++;
        if (i_areset_n) model_edge(s, a);
        @(negedge i_clk);
        check_outputs();
    endtask

    task automatic idle(input int n, input logic c);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, c);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_mem_rd"}, o_mem_rd, 0);
        check_eq({tag, "_addr"}, o_mem_addr, 0);
        check_eq({tag, "_tap_wr"}, o_tap_wr, 0);
        check_eq({tag, "_tap"}, o_tap, 0);
        check_eq({tag, "_ce"}, o_ce, 0);
        check_eq({tag, "_busy"}, o_busy, 0);
        check_eq({tag, "_done"}, o_done, 0);
        check_eq({tag, "_loaded"}, o_loaded, 0);
        check_eq({tag, "_dropped"}, o_dropped, 0);
    endtask

    task automatic async_reset();
        i_start = 1'b0;
        i_abort = 1'b0;
        i_ce = 1'b1;
        #2 i_areset_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        @(posedge i_clk);
        cyc++;
        @(negedge i_clk);
        i_areset_n = 1'b1;
        model_reset();
    endtask

    task automatic clear_counts();
        wr_count = 0;
        done_count = 0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            mem[i] = TW'(i * 3);
            fir[i] = '0;
        end
        i_ce = 1'b1;
        repeat (3) @(negedge i_clk);
        check_all_zero("rst");
        i_areset_n = 1'b1;

        // Basic load with samples offered throughout; start sampled at edge 10.
        clear_counts();
        while (cyc < 9) step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        idle(N + 4, 1'b1);
        check_eq("basic_writes", wr_count, N);
        check_eq("basic_dones", done_count, 1);
        check_eq("basic_loaded", o_loaded, 1);

        // Abort during the fifth write, then a clean reload.
        for (int i = 0; i < N; i++) mem[i] = TW'($urandom);
        clear_counts();
        step(1'b1, 1'b0, 1'b0);
        idle(5, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        idle(N + 4, 1'b1);
        check_eq("abort_writes", wr_count, 5);
        check_eq("abort_dones", done_count, 0);
        clear_counts();
        step(1'b1, 1'b0, 1'b1);
        idle(N + 4, 1'b0);
        check_eq("reload_writes", wr_count, N);
        check_eq("reload_dones", done_count, 1);

        // Second start mid-load is ignored.
        clear_counts();
        step(1'b1, 1'b0, 1'b1);
        idle(6, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        idle(N + 4, 1'b1);
        check_eq("busy_start_writes", wr_count, N);
        check_eq("busy_start_dones", done_count, 1);

        // Start and abort together: abort wins.
        clear_counts();
        step(1'b1, 1'b1, 1'b1);
        idle(5, 1'b1);
        check_eq("collide_writes", wr_count, 0);

        // Start on the done cycle chains a second load.
        for (int i = 0; i < N; i++) mem[i] = TW'($urandom);
        clear_counts();
        step(1'b1, 1'b0, 1'b1);
        idle(N + 1, 1'b1);
        check_eq("b2b_done_now", o_done, 1);
        step(1'b1, 1'b0, 1'b1);
        idle(N + 3, 1'b1);
        check_eq("b2b_writes", wr_count, 2 * N);
        check_eq("b2b_dones", done_count, 2);

        // Asynchronous reset in the middle of a load.
        clear_counts();
        step(1'b1, 1'b0, 1'b1);
        idle(6, 1'b1);
        async_reset();
        clear_counts();
        idle(5, 1'b1);
        check_eq("post_rst_writes", wr_count, 0);
        step(1'b1, 1'b0, 1'b1);
        idle(N + 3, 1'b1);
        check_eq("post_rst_dones", done_count, 1);

        // Random start/abort/sample traffic against the schedule model.
        for (int i = 0; i < N; i++) mem[i] = TW'($urandom);
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 7) == 0), ($urandom_range(0, 29) == 0),
                 1'($urandom_range(0, 1)));
        end
        idle(N + 4, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
